// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and mult_div_unit.
// The control unit is master; the arithmetic unit is slave.
interface mult_div_unit_if;
  logic        MultOp;
  logic        DivOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        Div0;
  logic        Done;

  modport master (
    output MultOp, DivOp, A, B,
    input  HI, LO, Div0, Done
  );

  modport slave (
    input  MultOp, DivOp, A, B,
    output HI, LO, Div0, Done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / 32/32 divide, one bit per clock.
// Results land in the architectural HI/LO pair and hold until the next commit.
module mult_div_unit (
  input  logic             clock,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIN  = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;
  state_t      start_st;
  state_t      other_st;

  logic        is_div;
  logic        sa;
  logic        sb;
  logic [5:0]  cnt;
  logic [31:0] opr;
  logic [63:0] acc;
  logic [31:0] rem;
  logic [31:0] quo;

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic        div0_q;
  logic        done_d;
  logic        div0_d;

  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        busy;
  logic        start;
  logic        start_div;
  logic        iter;
  logic        commit;

  logic [32:0] msum;
  logic [63:0] acc_n;
  logic [32:0] dshift;
  logic [32:0] dsub;
  logic        dge;
  logic [31:0] rem_n;
  logic [31:0] quo_n;
  logic [63:0] prod_f;
  logic [31:0] quo_f;
  logic [31:0] rem_f;

  assign b_zero = (bus.B == 32'd0);
  assign a_mag  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
  assign b_mag  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;

  assign busy      = (state == MULT) || (state == DIV);
  assign start_div = (state_n == DIV) || (state_n == ERR);
  assign start     = !busy && (state_n != state) &&
                     ((state_n == MULT) || start_div);

  assign iter   = ((state == MULT) && bus.MultOp) ||
                  ((state == DIV)  && bus.DivOp);
  assign commit = iter && (cnt == 6'd31);

  // Multiply has priority when both requests arrive together.
  always_comb begin
    start_st = IDLE;
    unique case (1'b1)
      bus.MultOp: start_st = MULT;
      bus.DivOp:  start_st = b_zero ? ERR : DIV;
      default:    start_st = IDLE;
    endcase
  end

  // Leaving FIN/ERR may launch the opposite op on the same edge.
  always_comb begin
    other_st = IDLE;
    if (is_div) begin
      if (bus.MultOp) other_st = MULT;
    end else begin
      if (bus.DivOp) other_st = b_zero ? ERR : DIV;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = start_st;
      MULT: begin
        if (!bus.MultOp)        state_n = IDLE;
        else if (cnt == 6'd31)  state_n = FIN;
      end
      DIV: begin
        if (!bus.DivOp)         state_n = IDLE;
        else if (cnt == 6'd31)  state_n = FIN;
      end
      FIN: begin
        if (is_div ? !bus.DivOp : !bus.MultOp)
          state_n = other_st;
      end
      ERR: begin
        if (!bus.DivOp) state_n = other_st;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    done_d = (state_n == FIN);
    div0_d = (state_n == ERR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      done_q <= done_d;
      div0_q <= div0_d;
    end
  end

  // Shift-add: multiplier sits in acc[31:0] and is consumed LSB first.
  assign msum  = {1'b0, acc[63:32]} +
                 {1'b0, (acc[0] ? opr : 32'd0)};
  assign acc_n = {msum, acc[31:1]};

  // Restoring step: dividend bits enter from quo MSB first.
  assign dshift = {rem, quo[31]};
  assign dsub   = dshift - {1'b0, opr};
  assign dge    = !dsub[32];
  assign rem_n  = dge ? dsub[31:0] : dshift[31:0];
  assign quo_n  = {quo[30:0], dge};

  assign prod_f = (sa ^ sb) ? (~acc_n + 64'd1) : acc_n;
  assign quo_f  = (sa ^ sb) ? (~quo_n + 32'd1) : quo_n;
  assign rem_f  = sa ? (~rem_n + 32'd1) : rem_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cnt    <= 6'd0;
      opr    <= 32'd0;
      acc    <= 64'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
    end else if (start) begin
      is_div <= start_div;
      sa     <= bus.A[31];
      sb     <= bus.B[31];
      cnt    <= 6'd0;
      rem    <= 32'd0;
      if (start_div) begin
        opr <= b_mag;
        quo <= a_mag;
        acc <= 64'd0;
      end else begin
        opr <= a_mag;
        quo <= 32'd0;
        acc <= {32'd0, b_mag};
      end
    end else if (iter) begin
      cnt <= cnt + 6'd1;
      if (state == DIV) begin
        rem <= rem_n;
        quo <= quo_n;
      end else begin
        acc <= acc_n;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (state == DIV) begin
        hi_q <= rem_f;
        lo_q <= quo_f;
      end else begin
        hi_q <= prod_f[63:32];
        lo_q <= prod_f[31:0];
      end
    end
  end

  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
  assign bus.Done = done_q;
  assign bus.Div0 = div0_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Sequential signed multiply/divide unit that executes the `mult` and `div` requests issued by the processor control unit. The control unit raises `MultOp` or `DivOp` and holds it while counting 32 iterations. This unit captures the operands, iterates one bit per clock, and commits the result to the architectural HI/LO registers. It also reports division by zero on `Div0` so the control unit can branch to the exception path.

## Interface
- No parameters; datapath width is fixed at 32 bits, iteration count at 32.
- `clock` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high.
- `MultOp` in 1: multiply request, level, held by the control unit for the whole operation.
- `DivOp` in 1: divide request, level, held for the whole operation.
- `A` in 32: rs operand (multiplicand / dividend), sampled only at the start edge.
- `B` in 32: rt operand (multiplier / divisor), sampled only at the start edge.
- `HI` out 32: high product word / remainder.
- `LO` out 32: low product word / quotient.
- `Div0` out 1: divisor was zero.
- `Done` out 1: result committed to HI/LO.

## Operation
- States: IDLE, MULT, DIV, FIN, ERR.
- IDLE: `MultOp`=1 moves to MULT; otherwise `DivOp`=1 moves to DIV. Multiply has priority if both are high. On the transition, latch |A| and |B|, the sign flags, and clear the iteration counter (6 bits) and the partial registers.
- DIV entry with B==0: go to ERR instead. Set `Div0`=1 and perform no iterations. HI/LO are unchanged.
- MULT: unsigned shift-add on magnitudes with a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- DIV: restoring division on magnitudes with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
- Each MULT/DIV cycle increments the counter. On the edge where the counter reaches 31 (32nd iteration), apply the sign fix and write HI/LO, then go to FIN.
- Multiply sign fix: negate the 64-bit product if sign(A)≠sign(B). HI gets bits 63:32 and LO gets bits 31:0.
- Divide sign fix: the quotient is negated if the signs differ, giving truncation toward zero. The remainder takes the sign of the dividend. LO gets the quotient and HI gets the remainder.
- 0x80000000 / 0xFFFFFFFF gives LO=0x80000000 (wraps) and HI=0. There is no exception.
- FIN: `Done`=1. Stay in FIN while the request that started the operation is high. When it drops, go to IDLE.
- ERR: `Div0`=1. Stay in ERR while `DivOp` is high. When it drops, go to IDLE.
- Abort: if the active request drops during MULT/DIV, return to IDLE on the next edge. HI/LO are not written and `Done` never asserts.
- Operand changes after the start edge are ignored. The other request input is ignored while busy.
- HI/LO change only at the commit edge or on reset, and hold their value indefinitely otherwise, so `mfhi`/`mflo` always read the last completed result.

## Timing
- Reset values: HI=0, LO=0, `Div0`=0, `Done`=0, state IDLE, counter 0. Reset asserted mid-operation returns to IDLE immediately and clears HI/LO.
- Edge E0 is the first edge at which the request is sampled high in IDLE. Iterations occur at edges E1..E32, with the commit at E32.
- HI/LO are valid and `Done`=1 in the cycle after E32. This is within the 33 cycles the control unit spends in its Mult/Div states before writing HI/LO.
- `Div0` is registered. It is high in the cycle after E0 and so is visible to the control unit at its second Div edge. It stays high until `DivOp` drops; it drops the cycle after `DivOp` is sampled low.
- `Done` deasserts the cycle after the request is sampled low. A new request can start at the same edge that leaves FIN only if it is a different op; otherwise one IDLE cycle is required.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Multiply A=7, B=0xFFFFFFFD (-3), `MultOp` held high: `Done` rises 33 cycles after E0, with HI=0xFFFFFFFF and LO=0xFFFFFFEB.
- Multiply A=B=0x80000000: HI=0x40000000, LO=0x00000000. Then multiply 0xFFFFFFFF×0xFFFFFFFF: HI=0, LO=1.
- Divide A=0xFFFFFFF9 (-7), B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divide A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide A=5, B=0 with HI/LO preloaded from a prior multiply: `Div0`=1 one cycle after E0, `Done` stays 0, HI/LO are unchanged, and `Div0` clears one cycle after `DivOp` drops.
- Abort: drop `MultOp` 10 cycles after E0. The unit returns to IDLE, HI/LO keep their previous values, and a following divide completes correctly.
- Assert `reset` at iteration 20 of a divide: all outputs are 0 immediately. After release, a multiply 3×4 gives HI=0, LO=12.
